// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared widths, state encoding and timing constants
// for the peripheral I/O bus arbiter.
package io_bus_pkg;

  localparam int IO_AW         = 8;
  localparam int IO_DW         = 8;
  localparam int IO_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/io_bus_arbiter_rr_pick.sv
// io_rr_pick: two-way round-robin pick, combinational.
// Contention goes to the master that was not granted last.
module io_rr_pick (
  input  logic [1:0] elig,
  input  logic       last,
  output logic       valid,
  output logic       gnt_id
);

  assign valid = |elig;

  always_comb begin
    gnt_id = 1'b0;
    unique case (1'b1)
      (elig == 2'b11): gnt_id = ~last;
      (elig == 2'b10): gnt_id = 1'b1;
      default:         gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin sharing of the 8-bit peripheral bus
// between the CPU LSU (m0) and the debug/loader engine (m1).
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter logic RESET_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [IO_AW-1:0] m0_addr,
  input  logic [IO_DW-1:0] m0_wdata,
  output logic             m0_ack,
  output logic [IO_DW-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [IO_AW-1:0] m1_addr,
  input  logic [IO_DW-1:0] m1_wdata,
  output logic             m1_ack,
  output logic [IO_DW-1:0] m1_rdata,
  output logic [IO_AW-1:0] bus_address,
  output logic [IO_DW-1:0] bus_wdata,
  output logic             bus_w_en,
  output logic             bus_r_en,
  input  logic [IO_DW-1:0] bus_rdata
);

  state_t state, state_nxt;
  logic   last, gnt_id, lat_we;
  logic   pick_valid, pick_id;
  logic   grant, ack_set, capture;
  logic   [1:0] elig;

  // A master in its ack cycle must not be re-granted on a stale req.
  assign elig = {m1_req & ~m1_ack, m0_req & ~m0_ack};

  io_rr_pick u_pick (
    .elig   (elig),
    .last   (last),
    .valid  (pick_valid),
    .gnt_id (pick_id)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = lat_we ? IDLE : WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant   = (state == IDLE) & pick_valid;
    ack_set = ((state == ISSUE) & lat_we) | (state == WAIT);
    capture = (state == WAIT);
  end

  // The bus address/data registers double as the request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      last        <= RESET_LAST;
      gnt_id      <= 1'b0;
      lat_we      <= 1'b0;
      bus_address <= '0;
      bus_wdata   <= '0;
      bus_w_en    <= 1'b0;
      bus_r_en    <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      bus_w_en <= 1'b0;
      bus_r_en <= 1'b0;
      if (grant) begin
        gnt_id      <= pick_id;
        last        <= pick_id;
        lat_we      <= pick_id ? m1_we : m0_we;
        bus_address <= pick_id ? m1_addr : m0_addr;
        bus_wdata   <= pick_id ? m1_wdata : m0_wdata;
        bus_w_en    <= pick_id ? m1_we : m0_we;
        bus_r_en    <= pick_id ? ~m1_we : ~m0_we;
      end
      m0_ack <= ack_set & ~gnt_id;
      m1_ack <= ack_set & gnt_id;
      if (capture) begin
        if (gnt_id) m1_rdata <= bus_rdata;
        else        m0_rdata <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed timing scenarios plus random two-master
// traffic checked against a transaction-level memory model.
module tb_io_bus_arbiter;
  import io_bus_pkg::*;

  localparam int MAX_LAT = 2 * (2 + IO_RD_LATENCY);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req [2];
  logic       we  [2];
  logic [7:0] addr[2];
  logic [7:0] wd  [2];
  logic       m0_ack, m1_ack;
  logic [7:0] m0_rdata, m1_rdata;
  logic [7:0] bus_address, bus_wdata, bus_rdata;
  logic       bus_w_en, bus_r_en;

  logic [7:0] mem    [256];
  logic [7:0] ref_mem[256];
  logic [7:0] exp_rd [2];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.RESET_LAST(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0_req      (req[0]),
    .m0_we       (we[0]),
    .m0_addr     (addr[0]),
    .m0_wdata    (wd[0]),
    .m0_ack      (m0_ack),
    .m0_rdata    (m0_rdata),
    .m1_req      (req[1]),
    .m1_we       (we[1]),
    .m1_addr     (addr[1]),
    .m1_wdata    (wd[1]),
    .m1_ack      (m1_ack),
    .m1_rdata    (m1_rdata),
    .bus_address (bus_address),
    .bus_wdata   (bus_wdata),
    .bus_w_en    (bus_w_en),
    .bus_r_en    (bus_r_en),
    .bus_rdata   (bus_rdata)
  );

  // Peripheral: registered read, one cycle after r_en.
  always @(posedge clk) begin
    if (bus_w_en) mem[bus_address] <= bus_wdata;
    if (bus_r_en) bus_rdata <= mem[bus_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    vectors += 8;
    if (bus_w_en !== 1'b0) begin miscompares++; $display("FAIL rst_w_en: got %0h want 0", bus_w_en); end
    if (bus_r_en !== 1'b0) begin miscompares++; $display("FAIL rst_r_en: got %0h want 0", bus_r_en); end
    if (bus_address !== 8'h00) begin miscompares++; $display("FAIL rst_addr: got %0h want 0", bus_address); end
    if (bus_wdata !== 8'h00) begin miscompares++; $display("FAIL rst_wdata: got %0h want 0", bus_wdata); end
    if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL rst_m0_ack: got %0h want 0", m0_ack); end
    if (m1_ack !== 1'b0) begin miscompares++; $display("FAIL rst_m1_ack: got %0h want 0", m1_ack); end
    if (m0_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_m0_rdata: got %0h want 0", m0_rdata); end
    if (m1_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_m1_rdata: got %0h want 0", m1_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h01; wd[0] = 8'hA5;
    tick();
    vectors += 5;
    if (bus_w_en !== 1'b1) begin miscompares++; $display("FAIL wr_w_en: got %0h want 1", bus_w_en); end
    if (bus_r_en !== 1'b0) begin miscompares++; $display("FAIL wr_r_en: got %0h want 0", bus_r_en); end
    if (bus_address !== 8'h01) begin miscompares++; $display("FAIL wr_addr: got %0h want 01", bus_address); end
    if (bus_wdata !== 8'hA5) begin miscompares++; $display("FAIL wr_wdata: got %0h want a5", bus_wdata); end
    if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL wr_early_ack: got %0h want 0", m0_ack); end
    tick();
    vectors += 4;
    if (m0_ack !== 1'b1) begin miscompares++; $display("FAIL wr_ack: got %0h want 1", m0_ack); end
    if (m1_ack !== 1'b0) begin miscompares++; $display("FAIL wr_other_ack: got %0h want 0", m1_ack); end
    if (m0_rdata !== 8'h00) begin miscompares++; $display("FAIL wr_rdata_kept: got %0h want 0", m0_rdata); end
    if (bus_w_en !== 1'b0) begin miscompares++; $display("FAIL wr_w_en_drop: got %0h want 0", bus_w_en); end
    req[0] = 1'b0;
    ref_mem[1] = 8'hA5;
    tick();
    vectors += 2;
    if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL wr_ack_width: got %0h want 0", m0_ack); end
    if (mem[1] !== 8'hA5) begin miscompares++; $display("FAIL wr_periph: got %0h want a5", mem[1]); end
  endtask

  task automatic test_single_read();
    mem[2] = 8'h3C; ref_mem[2] = 8'h3C;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h02; wd[1] = 8'h00;
    tick();
    vectors += 3;
    if (bus_r_en !== 1'b1) begin miscompares++; $display("FAIL rd_r_en: got %0h want 1", bus_r_en); end
    if (bus_w_en !== 1'b0) begin miscompares++; $display("FAIL rd_w_en: got %0h want 0", bus_w_en); end
    if (bus_address !== 8'h02) begin miscompares++; $display("FAIL rd_addr: got %0h want 02", bus_address); end
    tick();
    vectors += 3;
    if (m1_ack !== 1'b0) begin miscompares++; $display("FAIL rd_early_ack: got %0h want 0", m1_ack); end
    if (bus_r_en !== 1'b0) begin miscompares++; $display("FAIL rd_wait_r_en: got %0h want 0", bus_r_en); end
    if (bus_address !== 8'h02) begin miscompares++; $display("FAIL rd_wait_addr: got %0h want 02", bus_address); end
    tick();
    vectors += 2;
    if (m1_ack !== 1'b1) begin miscompares++; $display("FAIL rd_ack: got %0h want 1", m1_ack); end
    if (m1_rdata !== 8'h3C) begin miscompares++; $display("FAIL rd_data: got %0h want 3c", m1_rdata); end
    req[1] = 1'b0;
    tick();
    vectors += 3;
    if (m1_ack !== 1'b0) begin miscompares++; $display("FAIL rd_ack_width: got %0h want 0", m1_ack); end
    if (m1_rdata !== 8'h3C) begin miscompares++; $display("FAIL rd_hold: got %0h want 3c", m1_rdata); end
    if (m0_rdata !== 8'h00) begin miscompares++; $display("FAIL rd_other: got %0h want 0", m0_rdata); end
  endtask

  task automatic test_contention();
    logic [7:0] ea;
    do_reset();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h10; wd[0] = 8'h11;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h20; wd[1] = 8'h22;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vectors += 3;
      if (bus_w_en !== logic'(k % 2)) begin miscompares++; $display("FAIL cont_strobe c%0d: got %0h want %0h", k, bus_w_en, k % 2); end
      if (m0_ack !== (k == 2 || k == 6)) begin miscompares++; $display("FAIL cont_m0_ack c%0d: got %0h", k, m0_ack); end
      if (m1_ack !== (k == 4 || k == 8)) begin miscompares++; $display("FAIL cont_m1_ack c%0d: got %0h", k, m1_ack); end
      if (k % 2 == 1) begin
        ea = (k % 4 == 1) ? 8'h10 : 8'h20;
        vectors++;
        if (bus_address !== ea) begin miscompares++; $display("FAIL cont_order c%0d: got %0h want %0h", k, bus_address, ea); end
      end
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    ref_mem[8'h10] = 8'h11;
    ref_mem[8'h20] = 8'h22;
    tick();
    vectors++;
    if (bus_w_en !== 1'b0) begin miscompares++; $display("FAIL cont_extra: got %0h want 0", bus_w_en); end
    tick();
  endtask

  task automatic test_no_double_issue();
    int strobes;
    do_reset();
    strobes = 0;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h30; wd[0] = 8'h33;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (bus_w_en) strobes++;
      if (k == 3) req[0] = 1'b0;
    end
    vectors++;
    if (strobes !== 1) begin miscompares++; $display("FAIL nodbl_strobes: got %0d want 1", strobes); end
    strobes = 0;
    req[0] = 1'b1; addr[0] = 8'h31; wd[0] = 8'h34;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (bus_w_en) strobes++;
      if (k == 4) begin
        vectors++;
        if (bus_w_en !== 1'b1) begin miscompares++; $display("FAIL nodbl_second c4: got %0h want 1", bus_w_en); end
      end
      if (k == 5) begin
        vectors++;
        if (m0_ack !== 1'b1) begin miscompares++; $display("FAIL nodbl_ack2 c5: got %0h want 1", m0_ack); end
        req[0] = 1'b0;
      end
    end
    vectors++;
    if (strobes !== 2) begin miscompares++; $display("FAIL nodbl_held: got %0d want 2", strobes); end
    ref_mem[8'h30] = 8'h33;
    ref_mem[8'h31] = 8'h34;
  endtask

  task automatic test_reset_wait();
    do_reset();
    mem[5] = 8'h5A; ref_mem[5] = 8'h5A;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h05;
    tick();
    tick();
    vectors++;
    if (bus_r_en !== 1'b0) begin miscompares++; $display("FAIL rw_wait_r_en: got %0h want 0", bus_r_en); end
    rst = 1'b1;
    req[0] = 1'b0;
    tick();
    vectors += 6;
    if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL rw_no_ack: got %0h want 0", m0_ack); end
    if (m1_ack !== 1'b0) begin miscompares++; $display("FAIL rw_no_ack1: got %0h want 0", m1_ack); end
    if (bus_r_en !== 1'b0) begin miscompares++; $display("FAIL rw_r_en: got %0h want 0", bus_r_en); end
    if (bus_address !== 8'h00) begin miscompares++; $display("FAIL rw_addr: got %0h want 0", bus_address); end
    if (m0_rdata !== 8'h00) begin miscompares++; $display("FAIL rw_m0_rdata: got %0h want 0", m0_rdata); end
    if (m1_rdata !== 8'h00) begin miscompares++; $display("FAIL rw_m1_rdata: got %0h want 0", m1_rdata); end
    rst = 1'b0;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h05;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h02;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        vectors += 2;
        if (bus_r_en !== 1'b1) begin miscompares++; $display("FAIL rw_first_strobe: got %0h want 1", bus_r_en); end
        if (bus_address !== 8'h05) begin miscompares++; $display("FAIL rw_last_reset: got %0h want 05", bus_address); end
      end
      if (k == 3) begin
        vectors += 2;
        if (m0_ack !== 1'b1) begin miscompares++; $display("FAIL rw_m0_ack: got %0h want 1", m0_ack); end
        if (m0_rdata !== 8'h5A) begin miscompares++; $display("FAIL rw_m0_data: got %0h want 5a", m0_rdata); end
        req[0] = 1'b0;
      end
      if (k == 4) begin
        vectors++;
        if (bus_address !== 8'h02) begin miscompares++; $display("FAIL rw_m1_addr: got %0h want 02", bus_address); end
      end
      if (k == 6) begin
        vectors += 2;
        if (m1_ack !== 1'b1) begin miscompares++; $display("FAIL rw_m1_ack: got %0h want 1", m1_ack); end
        if (m1_rdata !== 8'h3C) begin miscompares++; $display("FAIL rw_m1_data: got %0h want 3c", m1_rdata); end
        req[1] = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    int  start[2];
    bit  pend[2];
    bit  a[2];
    bit  prev[2];
    int  strobes, acks;
    bit  allow;
    do_reset();
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    pend[0] = 1'b0; pend[1] = 1'b0;
    prev[0] = 1'b0; prev[1] = 1'b0;
    start[0] = 0; start[1] = 0;
    strobes = 0; acks = 0;
    for (int c = 0; c < 420; c++) begin
      allow = (c < 400);
      tick();
      vectors += 2;
      if (bus_w_en && bus_r_en) begin miscompares++; $display("FAIL rnd_mutex c%0d: got w=%0h r=%0h want not both", c, bus_w_en, bus_r_en); end
      if (bus_w_en || bus_r_en) strobes++;
      a[0] = m0_ack; a[1] = m1_ack;
      if ((a[0] && prev[0]) || (a[1] && prev[1]) || (a[0] && a[1])) begin
        miscompares++; $display("FAIL rnd_ack_pulse c%0d: got %0h%0h prev %0h%0h", c, a[1], a[0], prev[1], prev[0]);
      end
      prev = a;
      for (int m = 0; m < 2; m++) begin
        if (a[m]) begin
          acks++;
          vectors++;
          if (!pend[m] || (c - start[m]) > MAX_LAT) begin
            miscompares++; $display("FAIL rnd_ack_lat m%0d c%0d: got pend=%0d lat=%0d want pend=1 lat<=%0d", m, c, pend[m], c - start[m], MAX_LAT);
          end
          if (we[m]) ref_mem[addr[m]] = wd[m];
          else       exp_rd[m] = ref_mem[addr[m]];
          pend[m] = 1'b0;
        end
      end
      vectors += 2;
      if (m0_rdata !== exp_rd[0]) begin miscompares++; $display("FAIL rnd_m0_rdata c%0d: got %0h want %0h", c, m0_rdata, exp_rd[0]); end
      if (m1_rdata !== exp_rd[1]) begin miscompares++; $display("FAIL rnd_m1_rdata c%0d: got %0h want %0h", c, m1_rdata, exp_rd[1]); end
      for (int m = 0; m < 2; m++) begin
        if (a[m] || !req[m]) begin
          req[m] = 1'b0;
          if (allow && ($urandom % 3 == 0 || (a[m] && $urandom % 2 == 0))) begin
            req[m]   = 1'b1;
            we[m]    = 1'($urandom % 2);
            addr[m]  = 8'($urandom % 16);
            wd[m]    = 8'($urandom);
            pend[m]  = 1'b1;
            start[m] = a[m] ? c + 1 : c;
          end
        end
      end
    end
    vectors += 2;
    if (pend[0] || pend[1]) begin miscompares++; $display("FAIL rnd_drain: got pend=%0d%0d want 00", pend[1], pend[0]); end
    if (strobes !== acks) begin miscompares++; $display("FAIL rnd_strobe_ack: got strobes=%0d acks=%0d want equal", strobes, acks); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    req[0] = 1'b0; req[1] = 1'b0;
    we[0] = 1'b0;  we[1] = 1'b0;
    addr[0] = 8'h00; addr[1] = 8'h00;
    wd[0] = 8'h00;   wd[1] = 8'h00;
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_no_double_issue();
    test_reset_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
